cpu_mem_ctrl: RTL and testbench
===============================

# cpu_mem_ctrl

Parametrised memory/I-O access controller that sits between the multicycle CPU core and its memory. It replaces the CPU's single-cycle combinational memory path (memWrite, memWriteData, outAddr, memDataInbound) with a stall-capable request/acknowledge handshake. Each request is routed either to a synchronous RAM with configurable read latency or to a bank of memory-mapped I/O channels.

## Interface
Parameters:
- DATA_W, 16, data width of CPU, RAM and I/O words
- ADDR_W, 16, address width (≥ 9)
- IO_CH, 4, number of I/O channels (1..256)
- IO_PAGE, 'hFF, value of cpuAddr[ADDR_W-1:8] selecting the I/O page
- RAM_LAT, 1, RAM read latency in cycles from strobe to ramReadData valid (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- cpuReq  in  1  access request; held with fields stable until cpuAck
- cpuWrite  in  1  1 = write, 0 = read
- cpuAddr  in  ADDR_W  word address
- cpuWriteData  in  DATA_W  write data
- cpuAck  out  1  one-cycle completion pulse
- cpuReadData  out  DATA_W  read data, valid while cpuAck = 1
- ramEn  out  1  RAM access strobe, one cycle
- ramWe  out  1  RAM write enable, qualified by ramEn
- ramAddr  out  ADDR_W  RAM address
- ramWriteData  out  DATA_W  RAM write data
- ramReadData  in  DATA_W  RAM read data
- ioIn  in  IO_CH*DATA_W  input channel k occupies bits [k*DATA_W +: DATA_W]
- ioOut  out  IO_CH*DATA_W  registered output channels, same packing
- ioStrobe  out  IO_CH  one-cycle pulse on channel k when it is written

## Operation
- Decode: an access is I/O when cpuAddr[ADDR_W-1:8] == IO_PAGE. Otherwise it is RAM. The I/O offset is cpuAddr[7:0].
- I/O write, offset k < IO_CH: ioOut[k] <= cpuWriteData; ioStrobe[k] pulses.
- I/O read, offset k < IO_CH: returns ioIn[k], sampled in the decode cycle.
- I/O offset ≥ IO_CH: write dropped with no strobe; read returns 0. Both are still acknowledged.
- FSM states:
  - IDLE: samples cpuReq. Goes to IO, RAM_WR, RAM_RD or DRAIN.
  - IO: goes to ACK.
  - RAM_WR: strobe issued. Goes to ACK.
  - RAM_RD: strobe issued, then waits RAM_LAT cycles. Goes to ACK.
  - DRAIN: write-buffer flush. Goes to IDLE.
  - ACK: pulses cpuAck. Goes to IDLE.
- cpuReadData is registered when the access completes and held until the next completion.
- A request present in the cycle after cpuAck is treated as a new request.
- ramAddr and ramWriteData are registered and hold their last value. ramEn and ramWe are registered pulses.

## Timing
- Reset values: all outputs 0, ioOut 0, FSM in IDLE, write buffer empty. Asserting reset mid-access aborts it with no ack, and any buffered write is discarded.
- Cycle 0 is the cycle in which cpuReq is sampled in IDLE.
- I/O access: cpuAck in cycle 1. ioOut updates and ioStrobe pulse in cycle 1.
- RAM write: ramEn/ramWe in cycle 1, cpuAck in cycle 2.
- RAM read: ramEn in cycle 1, data captured in cycle 1+RAM_LAT, cpuAck in cycle 2+RAM_LAT.
- Throughput: one access in flight; no pipelining.

## Configuration
- CPU_MEM_WBUF_EN defined: a one-entry posted write buffer is built.
  - A RAM write is acknowledged in cycle 1, captured into the buffer, and drained to RAM (ramEn/ramWe) in the following cycle.
  - Any RAM access arriving while the buffer is full waits for the drain first, so a read-after-write to the same address returns the new data.
  - I/O accesses bypass the buffer and do not wait for it.
- CPU_MEM_WBUF_EN undefined: RAM writes take the 2-cycle path and the DRAIN state is absent.

## Structure
- Package cpu_mem_pkg holds:
  - the FSM state enum;
  - a localparam for the I/O offset width (8);
  - default IO_PAGE;
  - a helper function for channel slice extraction.
- Sub-module cpu_mem_io_regs holds the IO_CH output registers, the strobe generation and the read mux. The FSM, decode and write buffer stay in the top.

## Test plan
- RAM_LAT=2. Read of addr 'h0010 holding 'hBEEF -> ramEn in cycle 1, cpuAck in cycle 4, cpuReadData = 'hBEEF.
- I/O write 'h1234 to 'hFF02 -> ioOut[2] = 'h1234 and ioStrobe = 4'b0100 in cycle 1, cpuAck in cycle 1. Then read 'hFF01 with ioIn[1] = 'h00A5 -> cpuAck in cycle 1, cpuReadData = 'h00A5.
- Out-of-range I/O: write 'hFF09 with IO_CH=4 -> ack in cycle 1, ioStrobe stays 0, ioOut unchanged. Read 'hFF09 -> cpuReadData = 0.
- CPU_MEM_WBUF_EN defined. Write 'h5A5A to 'h0020, then immediately read 'h0020 -> write ack in cycle 1, drain strobe before the read strobe, read returns 'h5A5A.
- Reset pulled to 0 during RAM_RD -> all outputs 0 asynchronously, no cpuAck. After release a new request completes normally.
- DATA_W=32, IO_CH=8. Write 'hDEADBEEF to 'hFF07 -> ioOut bits [255:224] = 'hDEADBEEF.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and helpers for the CPU memory/I-O access controller.
//   - memState_e      : controller FSM states (DRAIN only exists when
//                       CPU_MEM_WBUF_EN is defined)
//   - IO_OFF_W        : width of the I/O page offset (low address bits)
//   - IO_PAGE_DEFAULT : default upper-address value selecting the I/O page
//   - chLsb()         : LSB position of channel k inside a packed channel bus
package cpu_mem_pkg;

  localparam int IO_OFF_W        = 8;
  localparam int IO_PAGE_DEFAULT = 'hFF;

  typedef enum logic [2:0] {
    IDLE,
    IO,
    RAM_WR,
    RAM_RD,
`ifdef CPU_MEM_WBUF_EN
    DRAIN,
`endif
    ACK
  } memState_e;

  // Channel k of a packed bus occupies [chLsb(k, w) +: w].
  function automatic int chLsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/cpu_mem_io_regs.sv
// cpu_mem_io_regs: memory-mapped I/O channel bank.
//   clk, reset   : clock, asynchronous active-low reset
//   wrEn         : one-cycle write request for channel 'offset'
//   offset       : I/O offset (channel number); offsets >= IO_CH are ignored
//   wrData       : data written to the selected output channel
//   ioIn         : packed input channels, channel k at [k*DATA_W +: DATA_W]
//   ioOut        : registered output channels, same packing
//   ioStrobe     : one-cycle pulse on the channel that was written
//   rdData       : combinational read mux of ioIn; 0 for out-of-range offsets
module cpu_mem_io_regs
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IO_CH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wrEn,
  input  logic [IO_OFF_W-1:0]       offset,
  input  logic [DATA_W-1:0]         wrData,
  input  logic [IO_CH*DATA_W-1:0]   ioIn,
  output logic [IO_CH*DATA_W-1:0]   ioOut,
  output logic [IO_CH-1:0]          ioStrobe,
  output logic [DATA_W-1:0]         rdData
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ioOut    <= '0;
      ioStrobe <= '0;
    end else begin
      for (int unsigned k = 0; k < IO_CH; k++) begin
        ioStrobe[k] <= wrEn && (32'(offset) == k);
        if (wrEn && (32'(offset) == k))
          ioOut[chLsb(int'(k), DATA_W) +: DATA_W] <= wrData;
      end
    end
  end

  always_comb begin
    rdData = '0;
    for (int unsigned k = 0; k < IO_CH; k++) begin
      if (32'(offset) == k)
        rdData = ioIn[chLsb(int'(k), DATA_W) +: DATA_W];
    end
  end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: request/acknowledge memory and I/O access controller for the
// multicycle CPU. Requests on the I/O page (cpuAddr[ADDR_W-1:8] == IO_PAGE) go
// to cpu_mem_io_regs, all others to a synchronous RAM with RAM_LAT read latency.
// Optional feature macro: CPU_MEM_WBUF_EN builds a one-entry posted write buffer.
//   clk, reset             : clock, asynchronous active-low reset
//   cpuReq/cpuWrite        : request (held until cpuAck), 1 = write
//   cpuAddr/cpuWriteData   : word address and write data
//   cpuAck/cpuReadData     : one-cycle completion pulse, read data (held)
//   ramEn/ramWe            : registered one-cycle RAM strobe, write enable
//   ramAddr/ramWriteData   : registered RAM address and write data
//   ramReadData            : RAM read data
//   ioIn/ioOut/ioStrobe    : I/O channel inputs, registered outputs, write pulses
module cpu_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int                           DATA_W  = 16,
  parameter int                           ADDR_W  = 16,
  parameter int                           IO_CH   = 4,
  parameter logic [ADDR_W-IO_OFF_W-1:0]   IO_PAGE = (ADDR_W-IO_OFF_W)'(IO_PAGE_DEFAULT),
  parameter int                           RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpuReq,
  input  logic                     cpuWrite,
  input  logic [ADDR_W-1:0]        cpuAddr,
  input  logic [DATA_W-1:0]        cpuWriteData,
  output logic                     cpuAck,
  output logic [DATA_W-1:0]        cpuReadData,
  output logic                     ramEn,
  output logic                     ramWe,
  output logic [ADDR_W-1:0]        ramAddr,
  output logic [DATA_W-1:0]        ramWriteData,
  input  logic [DATA_W-1:0]        ramReadData,
  input  logic [IO_CH*DATA_W-1:0]  ioIn,
  output logic [IO_CH*DATA_W-1:0]  ioOut,
  output logic [IO_CH-1:0]         ioStrobe
);

  memState_e           state, stateNext;
  logic [2:0]          latCnt, latCntNext;
  logic                ackNext, ramEnNext, ramWeNext;
  logic [DATA_W-1:0]   rdDataNext, ramWdataNext, ioRdData;
  logic [ADDR_W-1:0]   ramAddrNext;
  logic                isIo, ioWrEn;
  logic [IO_OFF_W-1:0] ioOffset;
`ifdef CPU_MEM_WBUF_EN
  logic                wbufValid, wbufValidNext;
  logic [ADDR_W-1:0]   wbufAddr, wbufAddrNext;
  logic [DATA_W-1:0]   wbufData, wbufDataNext;
`endif

  assign isIo     = (cpuAddr[ADDR_W-1:IO_OFF_W] == IO_PAGE);
  assign ioOffset = cpuAddr[IO_OFF_W-1:0];

  cpu_mem_io_regs #(
    .DATA_W (DATA_W),
    .IO_CH  (IO_CH)
  ) ioRegs (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (ioWrEn),
    .offset   (ioOffset),
    .wrData   (cpuWriteData),
    .ioIn     (ioIn),
    .ioOut    (ioOut),
    .ioStrobe (ioStrobe),
    .rdData   (ioRdData)
  );

  // All outputs are registered, so each "Next" value below becomes visible one
  // cycle later. I/O accesses raise the ack straight from IDLE so it coincides
  // with the ioOut update; the ACK state that follows is then a quiet cycle.
  always_comb begin
    stateNext    = state;
    latCntNext   = latCnt;
    ackNext      = 1'b0;
    rdDataNext   = cpuReadData;
    ramEnNext    = 1'b0;
    ramWeNext    = 1'b0;
    ramAddrNext  = ramAddr;
    ramWdataNext = ramWriteData;
    ioWrEn       = 1'b0;
`ifdef CPU_MEM_WBUF_EN
    wbufValidNext = wbufValid;
    wbufAddrNext  = wbufAddr;
    wbufDataNext  = wbufData;
`endif
    unique case (state)
      IDLE: begin
        if (cpuReq) begin
          if (isIo) begin
            stateNext = IO;
            ackNext   = 1'b1;
            ioWrEn    = cpuWrite;
            if (!cpuWrite) rdDataNext = ioRdData;
          end else if (cpuWrite) begin
`ifdef CPU_MEM_WBUF_EN
            // Posted write: ack now, DRAIN issues the RAM strobe before IDLE
            // can sample another request, so later reads see the new data.
            stateNext     = DRAIN;
            ackNext       = 1'b1;
            wbufValidNext = 1'b1;
            wbufAddrNext  = cpuAddr;
            wbufDataNext  = cpuWriteData;
`else
            stateNext    = RAM_WR;
            ramEnNext    = 1'b1;
            ramWeNext    = 1'b1;
            ramAddrNext  = cpuAddr;
            ramWdataNext = cpuWriteData;
`endif
          end else begin
            stateNext   = RAM_RD;
            ramEnNext   = 1'b1;
            ramAddrNext = cpuAddr;
            latCntNext  = '0;
          end
        end
      end
      IO:     stateNext = ACK;
      RAM_WR: begin
        stateNext = ACK;
        ackNext   = 1'b1;
      end
      RAM_RD: begin
        if (latCnt == 3'(RAM_LAT)) begin
          stateNext  = ACK;
          ackNext    = 1'b1;
          rdDataNext = ramReadData;
        end else begin
          latCntNext = latCnt + 3'd1;
        end
      end
`ifdef CPU_MEM_WBUF_EN
      DRAIN: begin
        stateNext = IDLE;
        if (wbufValid) begin
          ramEnNext     = 1'b1;
          ramWeNext     = 1'b1;
          ramAddrNext   = wbufAddr;
          ramWdataNext  = wbufData;
          wbufValidNext = 1'b0;
        end
      end
`endif
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      latCnt       <= '0;
      cpuAck       <= 1'b0;
      cpuReadData  <= '0;
      ramEn        <= 1'b0;
      ramWe        <= 1'b0;
      ramAddr      <= '0;
      ramWriteData <= '0;
`ifdef CPU_MEM_WBUF_EN
      wbufValid    <= 1'b0;
      wbufAddr     <= '0;
      wbufData     <= '0;
`endif
    end else begin
      state        <= stateNext;
      latCnt       <= latCntNext;
      cpuAck       <= ackNext;
      cpuReadData  <= rdDataNext;
      ramEn        <= ramEnNext;
      ramWe        <= ramWeNext;
      ramAddr      <= ramAddrNext;
      ramWriteData <= ramWdataNext;
`ifdef CPU_MEM_WBUF_EN
      wbufValid    <= wbufValidNext;
      wbufAddr     <= wbufAddrNext;
      wbufData     <= wbufDataNext;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: directed self-checking bench for cpu_mem_ctrl.
// dut  : DATA_W=16, IO_CH=4, RAM_LAT=2 with a behavioural RAM model.
// dut2 : DATA_W=32, IO_CH=8 for the wide I/O packing case.
// Expected write timing follows CPU_MEM_WBUF_EN when it is defined.
module tb_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpuReq = 1'b0, cpuWrite = 1'b0;
  logic [15:0] cpuAddr = '0, cpuWriteData = '0;
  logic        cpuAck;
  logic [15:0] cpuReadData;
  logic        ramEn, ramWe;
  logic [15:0] ramAddr, ramWriteData, ramReadData;
  logic [63:0] ioIn = {16'h3333, 16'h2222, 16'h00A5, 16'h1111};
  logic [63:0] ioOut;
  logic [3:0]  ioStrobe;

  logic         cpuReq2 = 1'b0, cpuWrite2 = 1'b0;
  logic [15:0]  cpuAddr2 = '0;
  logic [31:0]  cpuWriteData2 = '0;
  logic         cpuAck2;
  logic [31:0]  cpuReadData2;
  logic         ramEn2, ramWe2;
  logic [15:0]  ramAddr2;
  logic [31:0]  ramWriteData2;
  logic [31:0]  ramReadData2 = '0;
  logic [255:0] ioIn2 = '0;
  logic [255:0] ioOut2;
  logic [7:0]   ioStrobe2;

  int nChecks = 0;
  int nFail = 0;
  int cycNo = 0;
  int lastWrEnCyc = -1;
  int lastRdEnCyc = -1;

  always #5 clk = ~clk;

  cpu_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .IO_CH(4), .RAM_LAT(2)) dut (
    .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuWrite(cpuWrite),
    .cpuAddr(cpuAddr), .cpuWriteData(cpuWriteData), .cpuAck(cpuAck),
    .cpuReadData(cpuReadData), .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr),
    .ramWriteData(ramWriteData), .ramReadData(ramReadData), .ioIn(ioIn),
    .ioOut(ioOut), .ioStrobe(ioStrobe)
  );

  cpu_mem_ctrl #(.DATA_W(32), .ADDR_W(16), .IO_CH(8), .RAM_LAT(1)) dut2 (
    .clk(clk), .reset(reset), .cpuReq(cpuReq2), .cpuWrite(cpuWrite2),
    .cpuAddr(cpuAddr2), .cpuWriteData(cpuWriteData2), .cpuAck(cpuAck2),
    .cpuReadData(cpuReadData2), .ramEn(ramEn2), .ramWe(ramWe2), .ramAddr(ramAddr2),
    .ramWriteData(ramWriteData2), .ramReadData(ramReadData2), .ioIn(ioIn2),
    .ioOut(ioOut2), .ioStrobe(ioStrobe2)
  );

  // RAM model: data for a strobe in cycle 1 is valid from cycle 1+2.
  logic [15:0] mem [256];
  bit          memLoaded = 1'b0;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  always @(posedge clk) begin
    if (!memLoaded) begin
      mem[8'h10] <= 16'hBEEF;
      memLoaded  <= 1'b1;
    end
    if (ramEn && ramWe) mem[ramAddr[7:0]] <= ramWriteData;
    d1 <= mem[ramAddr[7:0]];
    d2 <= d1;
  end
  assign ramReadData = d2;

  always @(posedge clk) cycNo <= cycNo + 1;

  always @(negedge clk) begin
    if (ramEn) begin
      if (ramWe) lastWrEnCyc = cycNo;
      else       lastRdEnCyc = cycNo;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM in IDLE; that cycle is cycle 0.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        output int ackCyc, output int enCyc, output logic [15:0] rd,
                        output logic [3:0] strobe1, output logic [63:0] ioOut1);
    ackCyc = -1; enCyc = -1; rd = '0; strobe1 = '0; ioOut1 = '0;
    cpuReq = 1'b1; cpuWrite = wr; cpuAddr = addr; cpuWriteData = data;
    for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin strobe1 = ioStrobe; ioOut1 = ioOut; end
      if (ramEn && enCyc < 0) enCyc = c;
      if (cpuAck) begin ackCyc = c; rd = cpuReadData; end
    end
    cpuReq = 1'b0;
  endtask

  int          ackCyc, enCyc, c0;
  logic [15:0] rd;
  logic [3:0]  st1;
  logic [63:0] io1;
  bit          sawAck;
`ifdef CPU_MEM_WBUF_EN
  localparam int WR_ACK = 1;
  localparam int WR_EN  = -1;
  localparam int WR_STB = 2;
`else
  localparam int WR_ACK = 2;
  localparam int WR_EN  = 1;
  localparam int WR_STB = 1;
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cpuAck", 64'(cpuAck), 64'h0);
    check("rst_ramEn", 64'(ramEn), 64'h0);
    check("rst_ioOut", ioOut, 64'h0);
    check("rst_ramAddr", 64'(ramAddr), 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // RAM read, RAM_LAT=2
    access(1'b0, 16'h0010, 16'h0, ackCyc, enCyc, rd, st1, io1);
    check("rd_enCyc", 64'(enCyc), 64'd1);
    check("rd_ackCyc", 64'(ackCyc), 64'd4);
    check("rd_data", 64'(rd), 64'hBEEF);
    repeat (2) @(negedge clk);

    // I/O write to channel 2
    access(1'b1, 16'hFF02, 16'h1234, ackCyc, enCyc, rd, st1, io1);
    check("iow_ackCyc", 64'(ackCyc), 64'd1);
    check("iow_strobe", 64'(st1), 64'h4);
    check("iow_ioOut", io1, 64'h0000_1234_0000_0000);
    @(negedge clk);
    check("iow_strobe_drop", 64'(ioStrobe), 64'h0);
    @(negedge clk);

    // I/O read of channel 1
    access(1'b0, 16'hFF01, 16'h0, ackCyc, enCyc, rd, st1, io1);
    check("ior_ackCyc", 64'(ackCyc), 64'd1);
    check("ior_data", 64'(rd), 64'h00A5);
    repeat (2) @(negedge clk);

    // Out-of-range I/O write and read
    access(1'b1, 16'hFF09, 16'h5555, ackCyc, enCyc, rd, st1, io1);
    check("oow_ackCyc", 64'(ackCyc), 64'd1);
    check("oow_strobe", 64'(st1), 64'h0);
    check("oow_ioOut", io1, 64'h0000_1234_0000_0000);
    repeat (2) @(negedge clk);
    access(1'b0, 16'hFF09, 16'h0, ackCyc, enCyc, rd, st1, io1);
    check("oor_ackCyc", 64'(ackCyc), 64'd1);
    check("oor_data", 64'(rd), 64'h0);
    repeat (2) @(negedge clk);

    // RAM write followed by a read of the same address
    c0 = cycNo;
    access(1'b1, 16'h0020, 16'h5A5A, ackCyc, enCyc, rd, st1, io1);
    check("ramw_ackCyc", 64'(ackCyc), 64'(WR_ACK));
    check("ramw_enCyc", 64'(enCyc), 64'(WR_EN));
    @(negedge clk);
    access(1'b0, 16'h0020, 16'h0, ackCyc, enCyc, rd, st1, io1);
    check("raw_wrStrobeCyc", 64'(lastWrEnCyc - c0), 64'(WR_STB));
    check("raw_order", 64'(lastWrEnCyc < lastRdEnCyc), 64'h1);
    check("raw_ackCyc", 64'(ackCyc), 64'd4);
    check("raw_data", 64'(rd), 64'h5A5A);
    repeat (2) @(negedge clk);

    // Reset during RAM_RD
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0010;
    repeat (2) @(negedge clk);
    cpuReq = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_ramAddr", 64'(ramAddr), 64'h0);
    check("arst_cpuReadData", 64'(cpuReadData), 64'h0);
    check("arst_ioOut", ioOut, 64'h0);
    sawAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpuAck) sawAck = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpuAck) sawAck = 1'b1;
    end
    check("arst_noAck", 64'(sawAck), 64'h0);
    access(1'b0, 16'h0010, 16'h0, ackCyc, enCyc, rd, st1, io1);
    check("post_ackCyc", 64'(ackCyc), 64'd4);
    check("post_data", 64'(rd), 64'hBEEF);

    // Wide configuration: channel 7 of 8 x 32-bit
    cpuReq2 = 1'b1; cpuWrite2 = 1'b1; cpuAddr2 = 16'hFF07; cpuWriteData2 = 32'hDEADBEEF;
    @(negedge clk);
    cpuReq2 = 1'b0;
    check("w32_ack", 64'(cpuAck2), 64'h1);
    check("w32_strobe", 64'(ioStrobe2), 64'h80);
    check("w32_ch7", 64'(ioOut2[255:224]), 64'hDEADBEEF);
    check("w32_low", 64'(ioOut2[223:0] == '0), 64'h1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
